// File: rtl/gcn_pkg.sv
// Shared types and sizing for the GCN result streamer: label/node widths,
// histogram bin width and the streamer FSM state encoding.
package gcn_pkg;
  localparam int FEATURE_ROWS      = 6;
  localparam int WEIGHT_COLS       = 3;
  localparam int MAX_ADDRESS_WIDTH = 2;
  localparam int NODE_WIDTH        = $clog2(FEATURE_ROWS);
  localparam int COUNT_WIDTH       = $clog2(FEATURE_ROWS + 1);

  typedef logic [MAX_ADDRESS_WIDTH-1:0] label_t;
  typedef logic [NODE_WIDTH-1:0]        node_idx_t;
  typedef logic [COUNT_WIDTH-1:0]       count_t;

  typedef enum logic [1:0] {IDLE, STREAM, SUMMARY} streamer_state_t;

  function automatic logic label_in_range(input label_t l);
    return int'(l) < WEIGHT_COLS;
  endfunction
endpackage

// File: rtl/class_histogram.sv
// Per-class bin counters fed one label per increment; labels outside the
// class range raise a sticky bad flag instead of touching any bin.
module class_histogram
  import gcn_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_clear,
  input  logic   i_inc,
  input  label_t i_label,
  output count_t o_count [0:WEIGHT_COLS-1],
  output logic   o_bad
);
  logic w_in_range;
  logic r_bad;

  assign w_in_range = label_in_range(i_label);

  generate
    for (genvar gi = 0; gi < WEIGHT_COLS; gi++) begin : g_bin
      count_t r_bin;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_bin <= '0;
        else if (i_clear)
          r_bin <= '0;
        else if (i_inc && w_in_range && (i_label == label_t'(gi)))
          r_bin <= r_bin + count_t'(1);
      end
      assign o_count[gi] = r_bin;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bad <= 1'b0;
    else if (i_clear)
      r_bad <= 1'b0;
    else if (i_inc && !w_in_range)
      r_bad <= 1'b1;
  end

  assign o_bad = r_bad;
endmodule

// File: rtl/gcn_result_streamer.sv
// Captures the GCN label vector on a rising gcn_done, streams (node, label)
// beats over valid/ready, then pulses summary_valid with the class histogram.
module gcn_result_streamer
  import gcn_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      gcn_done,
  input  label_t    max_addi_answer [0:FEATURE_ROWS-1],
  output logic      out_valid,
  input  logic      out_ready,
  output node_idx_t out_node,
  output label_t    out_label,
  output logic      out_last,
  output count_t    class_count [0:WEIGHT_COLS-1],
  output logic      summary_valid,
  output logic      busy,
  output logic      overrun,
  output logic      bad_label
);
  streamer_state_t r_state, w_next_state;
  logic            r_done_q;
  label_t          r_buf [0:FEATURE_ROWS-1];
  node_idx_t       r_idx;
  logic            r_overrun;
  logic            w_trigger, w_capture, w_fire, w_at_last;

  assign w_trigger = gcn_done & ~r_done_q;
  assign w_capture = w_trigger & (r_state == IDLE);
  assign w_fire    = out_valid & out_ready;
  assign w_at_last = (r_idx == node_idx_t'(FEATURE_ROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    out_valid     = 1'b0;
    summary_valid = 1'b0;
    busy          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) w_next_state = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && w_at_last) w_next_state = SUMMARY;
      end
      SUMMARY: begin
        summary_valid = 1'b1;
        busy          = 1'b1;
        w_next_state  = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done_q <= 1'b0;
    else       r_done_q <= gcn_done;
  end

  // The label vector is only sampled on an accepted trigger.
  generate
    for (genvar gi = 0; gi < FEATURE_ROWS; gi++) begin : g_buf
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_buf[gi] <= '0;
        else if (w_capture) r_buf[gi] <= max_addi_answer[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_idx <= '0;
    else if (w_capture) r_idx <= '0;
    else if (w_fire)    r_idx <= w_at_last ? '0 : r_idx + node_idx_t'(1);
  end

  // Sticky until reset; a new frame deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_overrun <= 1'b0;
    else if (w_trigger && r_state != IDLE) r_overrun <= 1'b1;
  end

  assign out_node  = r_idx;
  assign out_label = r_buf[r_idx];
  assign out_last  = out_valid & w_at_last;
  assign overrun   = r_overrun;

  class_histogram u_hist (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_capture),
    .i_inc   (w_fire),
    .i_label (out_label),
    .o_count (class_count),
    .o_bad   (bad_label)
  );
endmodule

// File: tb/tb_gcn_result_streamer.sv
// Directed bench for gcn_result_streamer: a queue-based frame model checked
// every cycle, plus hand-computed per-scenario expectations.
module tb_gcn_result_streamer;
  import gcn_pkg::*;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      gcn_done = 1'b0;
  logic      out_ready = 1'b1;
  label_t    labels [0:FEATURE_ROWS-1];
  logic      out_valid, out_last, summary_valid, busy, overrun, bad_label;
  node_idx_t out_node;
  label_t    out_label;
  count_t    class_count [0:WEIGHT_COLS-1];

  always #5 clk = ~clk;

  gcn_result_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .gcn_done       (gcn_done),
    .max_addi_answer(labels),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_node       (out_node),
    .out_label      (out_label),
    .out_last       (out_last),
    .class_count    (class_count),
    .summary_valid  (summary_valid),
    .busy           (busy),
    .overrun        (overrun),
    .bad_label      (bad_label)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: pending labels in a queue, a summary flag, plain counters.
  int m_q[$];
  int m_node;
  bit m_sum, m_bad, m_ovr, m_prev;
  int m_hist [WEIGHT_COLS];

  task automatic model_clear();
    m_q.delete();
    m_node = 0; m_sum = 0; m_bad = 0; m_ovr = 0; m_prev = 0;
    for (int i = 0; i < WEIGHT_COLS; i++) m_hist[i] = 0;
  endtask

  task automatic model_step();
    bit trig, was_stream, was_sum;
    int l;
    trig = gcn_done && !m_prev;
    m_prev = gcn_done;
    was_stream = (m_q.size() > 0);
    was_sum = m_sum;
    if (was_sum) m_sum = 0;
    if (was_stream && out_ready) begin
      l = m_q.pop_front();
      if (l < WEIGHT_COLS) m_hist[l]++;
      else m_bad = 1;
      if (m_q.size() == 0) begin m_sum = 1; m_node = 0; end
      else m_node++;
    end
    if (trig) begin
      if (was_stream || was_sum) m_ovr = 1;
      else begin
        for (int i = 0; i < FEATURE_ROWS; i++) m_q.push_back(int'(labels[i]));
        m_node = 0; m_bad = 0;
        for (int i = 0; i < WEIGHT_COLS; i++) m_hist[i] = 0;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  int n_beats = 0;
  int n_sum = 0;

  initial begin
    bit e_valid;
    forever begin
      @(negedge clk);
      e_valid = (m_q.size() > 0);
      chk("out_valid", int'(out_valid), int'(e_valid));
      if (e_valid) begin
        chk("out_node", int'(out_node), m_node);
        chk("out_label", int'(out_label), m_q[0]);
        chk("out_last", int'(out_last), int'(m_q.size() == 1));
      end
      chk("summary_valid", int'(summary_valid), int'(m_sum));
      chk("busy", int'(busy), int'(e_valid || m_sum));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("bad_label", int'(bad_label), int'(m_bad));
      for (int i = 0; i < WEIGHT_COLS; i++) chk("class_count", int'(class_count[i]), m_hist[i]);
      if (out_valid && out_ready) n_beats++;
      if (summary_valid) n_sum++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_labels(input int v [FEATURE_ROWS]);
    for (int i = 0; i < FEATURE_ROWS; i++) labels[i] = label_t'(v[i]);
  endtask

  function automatic logic ready_for(input int mode, input int ph);
    if (mode == 0) return 1'b1;
    return (ph % 4 == 0) || (ph % 4 == 3);
  endfunction

  int first_cc_sum, first_node;

  // Raises gcn_done, drives out_ready by pattern, waits (bounded) for summary.
  task automatic frame(input string tag, input int mode, output int cycles, output int beats);
    int s0, b0;
    s0 = n_sum; b0 = n_beats; cycles = 0;
    out_ready = ready_for(mode, 0);
    gcn_done = 1'b1;
    while (n_sum == s0 && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        first_cc_sum = int'(class_count[0]) + int'(class_count[1]) + int'(class_count[2]);
        first_node = int'(out_node);
      end
      out_ready = ready_for(mode, cycles);
    end
    if (n_sum == s0) chk({tag, "_summary_timeout"}, 0, 1);
    beats = n_beats - b0;
    gcn_done = 1'b0;
    out_ready = 1'b1;
    $display("%s: frame done cycles=%0d beats=%0d cc=%0d,%0d,%0d bad=%0d ovr=%0d", tag, cycles, beats,
             class_count[0], class_count[1], class_count[2], bad_label, overrun);
  endtask

  task automatic chk_cc(input string tag, input int c0, input int c1, input int c2);
    chk({tag, "_cc0"}, int'(class_count[0]), c0);
    chk({tag, "_cc1"}, int'(class_count[1]), c1);
    chk({tag, "_cc2"}, int'(class_count[2]), c2);
  endtask

  initial begin
    int lab_a [FEATURE_ROWS] = '{0, 1, 2, 1, 0, 2};
    int lab_b [FEATURE_ROWS] = '{3, 0, 0, 0, 0, 1};
    int lab_c [FEATURE_ROWS] = '{2, 2, 2, 2, 2, 2};
    int lab_d [FEATURE_ROWS] = '{1, 1, 1, 1, 1, 1};
    int lab_e [FEATURE_ROWS] = '{1, 2, 0, 1, 2, 0};
    int cycles, beats, s0, k;

    set_labels(lab_a);
    cyc(2);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk_cc("rst", 0, 0, 0);
    reset = 1'b0;
    cyc(2);

    set_labels(lab_a);
    frame("t1", 0, cycles, beats);
    chk("t1_latency", cycles, 8);
    chk("t1_beats", beats, 6);
    chk_cc("t1", 2, 2, 2);
    chk("t1_bad", int'(bad_label), 0);
    cyc(2);

    frame("t2", 1, cycles, beats);
    chk("t2_beats", beats, 6);
    chk_cc("t2", 2, 2, 2);
    cyc(2);

    set_labels(lab_b);
    frame("t3", 0, cycles, beats);
    chk_cc("t3", 4, 1, 0);
    chk("t3_bad", int'(bad_label), 1);
    cyc(2);

    set_labels(lab_a);
    s0 = n_sum;
    gcn_done = 1'b1;
    cyc(2);
    gcn_done = 1'b0;
    set_labels(lab_c);
    cyc(1);
    gcn_done = 1'b1;
    cyc(20);
    gcn_done = 1'b0;
    cyc(3);
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_frames", n_sum - s0, 1);
    chk_cc("t4", 2, 2, 2);
    $display("t4: overrun frame cc=%0d,%0d,%0d ovr=%0d", class_count[0], class_count[1], class_count[2], overrun);

    set_labels(lab_d);
    frame("t5", 0, cycles, beats);
    chk("t5_clear_on_trigger", first_cc_sum, 0);
    chk_cc("t5", 0, 6, 0);
    chk("t5_overrun_kept", int'(overrun), 1);
    cyc(2);

    set_labels(lab_e);
    gcn_done = 1'b1;
    k = 0;
    while (!(out_valid && out_node == node_idx_t'(3)) && k < 20) begin cyc(1); k++; end
    if (k >= 20) chk("t6_reach_beat3_timeout", 0, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_node", int'(out_node), 0);
    chk("t6_rst_label", int'(out_label), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_overrun", int'(overrun), 0);
    chk_cc("t6_rst", 0, 0, 0);
    s0 = n_sum;
    gcn_done = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    chk("t6_no_summary", n_sum - s0, 0);
    $display("t6: reset mid-frame summaries=%0d", n_sum - s0);
    set_labels(lab_a);
    frame("t6", 0, cycles, beats);
    chk("t6_first_node", first_node, 0);
    chk("t6_beats", beats, 6);
    chk("t6_latency", cycles, 8);
    chk_cc("t6", 2, 2, 2);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
